// File: rtl/rvvi_depacketizer.sv
// Receive side of the RVVI trace link: strips a 4-word Ethernet header and reassembles one trace record.
// Optional EtherType filtering is enabled by defining RVVI_DEPACKETIZER_ETHERTYPE_CHECK_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_HEADER  | counting header beats 0..3
// S_PAYLOAD | storing payload beat word_cnt_q into the shadow record
// S_DISCARD | dropping beats of a rejected frame until its last beat
// S_HOLD    | record presented on valid/ready, input stream stalled
module rvvi_depacketizer #(
  parameter int          XLEN          = 64,
  parameter int          MAX_CSRS      = 5,
  parameter logic [15:0] ETHER_TYPE    = 16'h005C,
  localparam int         RVVI_W        = 72 + 5*XLEN + MAX_CSRS*(XLEN+16),
  localparam int         PAYLOAD_WORDS = (RVVI_W + 31) / 32
) (
  input  logic              m_axi_aclk,
  input  logic              m_axi_aresetn,
  input  logic [31:0]       RvviAxiRdata,
  input  logic [3:0]        RvviAxiRkeep,
  input  logic              RvviAxiRvalid,
  input  logic              RvviAxiRlast,
  output logic              RvviAxiRready,
  output logic              valid,
  input  logic              ready,
  output logic [RVVI_W-1:0] rvvi,
  output logic [31:0]       GoodFrameCount,
  output logic [31:0]       BadFrameCount
);

  localparam int WC_W  = (PAYLOAD_WORDS > 4) ? $clog2(PAYLOAD_WORDS) : 2;
  localparam int SH_IW = $clog2(RVVI_W);

  typedef enum logic [1:0] {
    S_HEADER,
    S_PAYLOAD,
    S_DISCARD,
    S_HOLD
  } state_t;

  state_t            state_q;
  logic [WC_W-1:0]   word_cnt_q;
  logic [WC_W-1:0]   word_cnt_d;
  logic              valid_q;
  logic              rready_q;
  logic [RVVI_W-1:0] shadow_q;
  logic [31:0]       good_cnt_q;
  logic [31:0]       good_cnt_d;
  logic [31:0]       bad_cnt_q;
  logic [31:0]       bad_cnt_d;

  logic beat_ok;
  logic hdr_last_word;
  logic pl_last_word;
  logic type_ok;
  logic unused_keep;

  assign unused_keep   = ^RvviAxiRkeep;
  assign beat_ok       = RvviAxiRvalid & rready_q;
  assign hdr_last_word = (word_cnt_q == WC_W'(3));
  assign pl_last_word  = (word_cnt_q == WC_W'(PAYLOAD_WORDS - 1));
  assign word_cnt_d    = word_cnt_q + WC_W'(1);
  assign good_cnt_d    = good_cnt_q + 32'd1;
  assign bad_cnt_d     = bad_cnt_q + 32'd1;

`ifdef RVVI_DEPACKETIZER_ETHERTYPE_CHECK_EN
  // EtherType travels big-endian on the wire: MSB lands in byte 0 of word 3.
  assign type_ok = ({RvviAxiRdata[7:0], RvviAxiRdata[15:8]} == ETHER_TYPE);
`else
  logic [15:0] unused_ether_type;
  assign unused_ether_type = ETHER_TYPE;
  assign type_ok           = 1'b1;
`endif

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q    <= S_HEADER;
      word_cnt_q <= '0;
      valid_q    <= 1'b0;
      rready_q   <= 1'b1;
      shadow_q   <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_HEADER: begin
          if (beat_ok) begin
            if (RvviAxiRlast) begin
              bad_cnt_q  <= bad_cnt_d;
              word_cnt_q <= '0;
            end else if (hdr_last_word) begin
              word_cnt_q <= '0;
              state_q    <= type_ok ? S_PAYLOAD : S_DISCARD;
            end else begin
              word_cnt_q <= word_cnt_d;
            end
          end
        end

        S_PAYLOAD: begin
          if (beat_ok) begin
            // Bits of the final word beyond RVVI_W simply have no home.
            for (int b = 0; b < RVVI_W; b++) begin
              if (word_cnt_q == WC_W'(b / 32)) begin
                shadow_q[SH_IW'(b)] <= RvviAxiRdata[5'(b % 32)];
              end
            end
            if (RvviAxiRlast) begin
              word_cnt_q <= '0;
              if (pl_last_word) begin
                state_q  <= S_HOLD;
                valid_q  <= 1'b1;
                rready_q <= 1'b0;
              end else begin
                state_q   <= S_HEADER;
                bad_cnt_q <= bad_cnt_d;
              end
            end else if (pl_last_word) begin
              word_cnt_q <= '0;
              state_q    <= S_DISCARD;
            end else begin
              word_cnt_q <= word_cnt_d;
            end
          end
        end

        S_DISCARD: begin
          if (beat_ok && RvviAxiRlast) begin
            bad_cnt_q <= bad_cnt_d;
            state_q   <= S_HEADER;
          end
        end

        S_HOLD: begin
          if (ready) begin
            good_cnt_q <= good_cnt_d;
            valid_q    <= 1'b0;
            rready_q   <= 1'b1;
            state_q    <= S_HEADER;
          end
        end

        default: begin
          state_q    <= S_HEADER;
          word_cnt_q <= '0;
          valid_q    <= 1'b0;
          rready_q   <= 1'b1;
        end
      endcase
    end
  end

  assign RvviAxiRready  = rready_q;
  assign valid          = valid_q;
  assign rvvi           = shadow_q;
  assign GoodFrameCount = good_cnt_q;
  assign BadFrameCount  = bad_cnt_q;

endmodule

// File: tb/tb_rvvi_depacketizer.sv
// Directed bench for rvvi_depacketizer at XLEN=64, MAX_CSRS=5 (792-bit record, 25 payload words).
module tb_rvvi_depacketizer;

  localparam int          RW      = 792;
  localparam logic [31:0] W3_GOOD = 32'hBEEF_5C00;
  localparam logic [31:0] W3_IP   = 32'hBEEF_0008;

  logic          clk;
  logic          rst_n;
  logic [31:0]   RvviAxiRdata;
  logic [3:0]    RvviAxiRkeep;
  logic          RvviAxiRvalid;
  logic          RvviAxiRlast;
  logic          RvviAxiRready;
  logic          valid;
  logic          ready;
  logic [RW-1:0] rvvi;
  logic [31:0]   GoodFrameCount;
  logic [31:0]   BadFrameCount;

  int n_total = 0;
  int n_bad   = 0;

  rvvi_depacketizer dut (
    .m_axi_aclk     (clk),
    .m_axi_aresetn  (rst_n),
    .RvviAxiRdata   (RvviAxiRdata),
    .RvviAxiRkeep   (RvviAxiRkeep),
    .RvviAxiRvalid  (RvviAxiRvalid),
    .RvviAxiRlast   (RvviAxiRlast),
    .RvviAxiRready  (RvviAxiRready),
    .valid          (valid),
    .ready          (ready),
    .rvvi           (rvvi),
    .GoodFrameCount (GoodFrameCount),
    .BadFrameCount  (BadFrameCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] exp_rvvi(input logic [31:0] base);
    logic [799:0] t;
    t = '0;
    for (int k = 0; k < 25; k++) t[32*k +: 32] = base + 32'(k);
    return t[RW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [799:0] obs, input logic [799:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_beat(input logic [31:0] d, input logic l);
    int guard;
    guard = 0;
    RvviAxiRdata  = d;
    RvviAxiRlast  = l;
    RvviAxiRvalid = 1'b1;
    while (RvviAxiRready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      n_total++;
      n_bad++;
      $error("FAIL beat_timeout observed=stalled expected=ready");
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] w3, input logic [31:0] base,
                            input int first, input int last_idx, input bit with_last);
    logic [31:0] d;
    for (int i = first; i <= last_idx; i++) begin
      if (i < 3)       d = 32'h1100_0000 + 32'(i);
      else if (i == 3) d = w3;
      else             d = base + 32'(i - 4);
      send_beat(d, with_last && (i == last_idx));
      if (i != last_idx) chk("valid_mid_frame", valid, 1'b0);
    end
    RvviAxiRvalid = 1'b0;
    RvviAxiRlast  = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    RvviAxiRdata  = '0;
    RvviAxiRkeep  = 4'hF;
    RvviAxiRvalid = 1'b0;
    RvviAxiRlast  = 1'b0;
    ready         = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", valid, 1'b0);
    chk("rst_rready", RvviAxiRready, 1'b1);
    chk("rst_rvvi", rvvi, '0);
    chk("rst_good", GoodFrameCount, 32'd0);
    chk("rst_bad", BadFrameCount, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // good frame, consumer always ready
    send_frame(W3_GOOD, 32'hA000_0000, 0, 28, 1'b1);
    chk("good_valid", valid, 1'b1);
    chk("good_word0", rvvi[31:0], 32'hA000_0000);
    chk("good_top", rvvi[791:768], 24'h000018);
    chk("good_rvvi", rvvi, exp_rvvi(32'hA000_0000));
    chk("good_rready_hold", RvviAxiRready, 1'b0);
    @(negedge clk);
    chk("good_count", GoodFrameCount, 32'd1);
    chk("good_valid_drop", valid, 1'b0);
    chk("good_rready_back", RvviAxiRready, 1'b1);
    chk("good_bad", BadFrameCount, 32'd0);

    // consumer back-pressure with the next frame's first beat waiting
    ready = 1'b0;
    send_frame(W3_GOOD, 32'hB000_0000, 0, 28, 1'b1);
    chk("bp_valid_rise", valid, 1'b1);
    RvviAxiRdata  = 32'h1100_0000;
    RvviAxiRlast  = 1'b0;
    RvviAxiRvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", valid, 1'b1);
      chk("bp_rready", RvviAxiRready, 1'b0);
      chk("bp_rvvi", rvvi, exp_rvvi(32'hB000_0000));
      chk("bp_good", GoodFrameCount, 32'd1);
    end
    ready = 1'b1;
    @(negedge clk);
    chk("bp_good_after", GoodFrameCount, 32'd2);
    chk("bp_valid_after", valid, 1'b0);
    chk("bp_rready_after", RvviAxiRready, 1'b1);
    send_frame(W3_GOOD, 32'hD000_0000, 0, 28, 1'b1);
    chk("bp2_valid", valid, 1'b1);
    chk("bp2_rvvi", rvvi, exp_rvvi(32'hD000_0000));
    @(negedge clk);
    chk("bp2_good", GoodFrameCount, 32'd3);
    chk("bp2_bad", BadFrameCount, 32'd0);

    // short frame: last on payload beat 20
    send_frame(W3_GOOD, 32'hC000_0000, 0, 24, 1'b1);
    chk("short_valid", valid, 1'b0);
    chk("short_bad", BadFrameCount, 32'd1);
    chk("short_good", GoodFrameCount, 32'd3);
    chk("short_rready", RvviAxiRready, 1'b1);
    send_frame(W3_GOOD, 32'hE000_0000, 0, 28, 1'b1);
    chk("after_short_valid", valid, 1'b1);
    chk("after_short_rvvi", rvvi, exp_rvvi(32'hE000_0000));
    @(negedge clk);
    chk("after_short_good", GoodFrameCount, 32'd4);

    // long frame: 32 beats
    send_frame(W3_GOOD, 32'hF000_0000, 0, 31, 1'b1);
    chk("long_valid", valid, 1'b0);
    chk("long_bad", BadFrameCount, 32'd2);
    chk("long_good", GoodFrameCount, 32'd4);

    // EtherType 0x0800
    send_frame(W3_IP, 32'h5000_0000, 0, 28, 1'b1);
`ifdef RVVI_DEPACKETIZER_ETHERTYPE_CHECK_EN
    chk("etype_valid", valid, 1'b0);
    chk("etype_bad", BadFrameCount, 32'd3);
    chk("etype_good", GoodFrameCount, 32'd4);
`else
    chk("etype_valid", valid, 1'b1);
    chk("etype_rvvi", rvvi, exp_rvvi(32'h5000_0000));
    @(negedge clk);
    chk("etype_good", GoodFrameCount, 32'd5);
    chk("etype_bad", BadFrameCount, 32'd2);
`endif

    // reset after payload beat 10, then finish that frame
    send_frame(W3_GOOD, 32'hA000_0000, 0, 14, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", valid, 1'b0);
    chk("mrst_rready", RvviAxiRready, 1'b1);
    chk("mrst_rvvi", rvvi, '0);
    chk("mrst_good", GoodFrameCount, 32'd0);
    chk("mrst_bad", BadFrameCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(W3_GOOD, 32'hA000_0000, 15, 28, 1'b1);
    chk("tail_valid", valid, 1'b0);
    chk("tail_bad", BadFrameCount, 32'd1);
    chk("tail_good", GoodFrameCount, 32'd0);
    send_frame(W3_GOOD, 32'h7000_0000, 0, 28, 1'b1);
    chk("post_rst_valid", valid, 1'b1);
    chk("post_rst_rvvi", rvvi, exp_rvvi(32'h7000_0000));
    @(negedge clk);
    chk("post_rst_good", GoodFrameCount, 32'd1);
    chk("post_rst_bad", BadFrameCount, 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
